// File: rtl/fpu_selftest.sv
// rtl/fpu_selftest.sv - on-chip FPU self-test sequencer with ULP-tolerant result checking
module fpu_selftest #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int DEPTH   = 1024,
  parameter int TOL_ULP = 4,
  parameter int TIMEOUT = 64,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = 2 + 3*W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_data,
  input  logic [AW:0]   num_vectors,
  input  logic          run,
  output logic          fpu_start,
  output logic [1:0]    fpu_funct,
  output logic [W-1:0]  fpu_a,
  output logic [W-1:0]  fpu_b,
  input  logic [W-1:0]  fpu_o,
  input  logic          fpu_finish,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW:0]   vec_count,
  output logic [AW-1:0] first_fail,
  output logic          timeout_seen
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [W:0]    TOL       = (W+1)'(TOL_ULP);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [W-1:0]  SIGN_BIT  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, CHECK, DONE} state_t;

  state_t        state;
  logic [LW-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW:0]   count;
  logic [W-1:0]  exp_q;
  logic [W-1:0]  res_q;
  logic [TW-1:0] wait_cnt;
  logic          timed_out;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return x[W-2:0] == '0;
  endfunction

  // Monotonic integer key: adjacent floats differ by one, across the sign boundary too.
  function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : (x ^ SIGN_BIT);
  endfunction

  logic [W:0] key_o;
  logic [W:0] key_e;
  logic [W:0] diff;
  logic       match;
  logic       vec_fail;
  logic       last_vec;

  always_comb begin
    key_o = {1'b0, order_key(res_q)};
    key_e = {1'b0, order_key(exp_q)};
    diff  = (key_o >= key_e) ? (key_o - key_e) : (key_e - key_o);
    match = 1'b0;
    if (res_q == exp_q)
      match = 1'b1;
    else if (is_nan(res_q) || is_nan(exp_q))
      match = is_nan(res_q) && is_nan(exp_q);
    else if (is_zero(res_q) && is_zero(exp_q))
      match = 1'b1;
    else
      match = (diff <= TOL);
    vec_fail = timed_out || !match;
    last_vec = (({1'b0, idx} + (AW+1)'(1)) == count);
  end

  always_ff @(posedge clk) begin
    if (load_we && !busy)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fpu_start    <= 1'b0;
      fpu_funct    <= '0;
      fpu_a        <= '0;
      fpu_b        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      vec_count    <= '0;
      first_fail   <= '0;
      timeout_seen <= 1'b0;
      idx          <= '0;
      count        <= '0;
      exp_q        <= '0;
      res_q        <= '0;
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (run) begin
            err_count    <= '0;
            vec_count    <= '0;
            first_fail   <= '0;
            timeout_seen <= 1'b0;
            idx          <= '0;
            count        <= (num_vectors > DEPTH_CNT) ? DEPTH_CNT : num_vectors;
            if (num_vectors == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        FETCH: begin
          // The operand registers double as the memory read register.
          {fpu_funct, fpu_a, fpu_b, exp_q} <= mem[idx];
          fpu_start <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          wait_cnt  <= '0;
          timed_out <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (fpu_finish) begin
            res_q <= fpu_o;
            state <= CHECK;
          end else if (wait_cnt == WAIT_LAST) begin
            timed_out    <= 1'b1;
            timeout_seen <= 1'b1;
            state        <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        CHECK: begin
          vec_count <= vec_count + (AW+1)'(1);
          if (vec_fail) begin
            if (err_count != '1)
              err_count <= err_count + (AW+1)'(1);
            if (err_count == '0)
              first_fail <= idx;
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !vec_fail;
          end else begin
            idx   <= idx + AW'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_selftest.sv
// tb/tb_fpu_selftest.sv - directed self-checking bench for fpu_selftest
module tb_fpu_selftest;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_we = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [2+3*W-1:0] load_data = '0;
  logic [AW:0]     num_vectors = '0;
  logic            run = 1'b0;
  logic            fpu_start;
  logic [1:0]      fpu_funct;
  logic [W-1:0]    fpu_a;
  logic [W-1:0]    fpu_b;
  logic [W-1:0]    fpu_o;
  logic            fpu_finish;
  logic            busy;
  logic            done;
  logic            pass;
  logic [AW:0]     err_count;
  logic [AW:0]     vec_count;
  logic [AW-1:0]   first_fail;
  logic            timeout_seen;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int resp_lat [64];
  logic [W-1:0] resp_val [64];
  int op_cnt = 0;
  int start_cnt = 0;
  int wide_cnt = 0;
  int st_log [64];
  logic [W-1:0] a_log [64];
  logic start_prev = 1'b0;
  int run_cyc = 0;
  int done_cyc = 0;
  int base = 0;

  fpu_selftest #(
    .EXP_W(8), .MAN_W(23), .DEPTH(DEPTH), .TOL_ULP(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .num_vectors(num_vectors), .run(run),
    .fpu_start(fpu_start), .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_o(fpu_o), .fpu_finish(fpu_finish),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count),
    .first_fail(first_fail), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fpu_start && start_prev) wide_cnt++;
    start_prev = fpu_start;
  end

  // FPU stand-in: answers each start with the next scripted latency/result; latency 0 never answers.
  initial begin : fpu_model
    int lat;
    logic [W-1:0] val;
    fpu_finish = 1'b0;
    fpu_o = '0;
    forever begin
      @(negedge clk);
      if (fpu_start) begin
        st_log[start_cnt] = cyc;
        a_log[start_cnt] = fpu_a;
        start_cnt++;
        lat = resp_lat[op_cnt];
        val = resp_val[op_cnt];
        op_cnt++;
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1;
          fpu_finish = 1'b1;
          fpu_o = val;
          @(posedge clk);
          #1;
          fpu_finish = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int i, input logic [1:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] e);
    @(negedge clk);
    load_we = 1'b1;
    load_addr = AW'(i);
    load_data = {f, a, b, e};
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic set_resp(input int k, input int lat, input logic [W-1:0] val);
    resp_lat[op_cnt + k] = lat;
    resp_val[op_cnt + k] = val;
  endtask

  task automatic do_run(input int n);
    @(negedge clk);
    num_vectors = (AW+1)'(n);
    run = 1'b1;
    run_cyc = cyc;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    if (!done) check("done_wait_expired", 0, 1);
  endtask

  task automatic wait_start(input int target, input int max);
    int n = 0;
    while (start_cnt < target && n < max) begin
      @(negedge clk);
      n++;
    end
    if (start_cnt < target) check("start_wait_expired", start_cnt, target);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_start", fpu_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_vec", vec_count, 0);
    check("rst_a", fpu_a, 0);
    check("rst_tmo", timeout_seen, 0);
    rst_n = 1'b1;

    // Single exact vector, L=5
    load(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_resp(0, 5, 32'h40400000);
    base = start_cnt;
    do_run(1);
    check("busy_after_run", busy, 1);
    wait_done(100);
    check("start_latency", st_log[base] - run_cyc, 2);
    check("done_latency", done_cyc - st_log[base], 7);
    check("t1_operand_a", a_log[base], 32'h3F800000);
    check("t1_pass", pass, 1);
    check("t1_vec", vec_count, 1);
    check("t1_busy_end", busy, 0);
    check("t1_starts", start_cnt - base, 1);

    // Within tolerance (+3 ULP) then beyond (+5 ULP)
    set_resp(0, 4, 32'h40400003);
    do_run(1);
    wait_done(100);
    check("ulp3_pass", pass, 1);
    check("ulp3_err", err_count, 0);
    set_resp(0, 4, 32'h40400005);
    do_run(1);
    wait_done(100);
    check("ulp5_err", err_count, 1);
    check("ulp5_first", first_fail, 0);
    check("ulp5_pass", pass, 0);

    // Failures at idx 1 and 2 (wrong value, NaN vs inf)
    load(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    load(1, 2'd1, 32'h40000000, 32'h3F800000, 32'h3F800000);
    load(2, 2'd2, 32'h40000000, 32'h40000000, 32'h7F800000);
    set_resp(0, 2, 32'h40400000);
    set_resp(1, 2, 32'h40000000);
    set_resp(2, 2, 32'h7FC00000);
    do_run(3);
    wait_done(100);
    check("t3_err", err_count, 2);
    check("t3_first", first_fail, 1);
    check("t3_pass", pass, 0);
    check("t3_vec", vec_count, 3);

    // Special-value passes: NaN payloads, signed zeros, sign-crossing ULPs, negative ULPs
    load(0, 2'd0, 32'h0, 32'h0, 32'h7FC00000);
    load(1, 2'd0, 32'h0, 32'h0, 32'h80000000);
    load(2, 2'd0, 32'h0, 32'h0, 32'h00000001);
    load(3, 2'd0, 32'h0, 32'h0, 32'hBF800000);
    set_resp(0, 1, 32'hFFC00001);
    set_resp(1, 1, 32'h00000000);
    set_resp(2, 1, 32'h80000001);
    set_resp(3, 1, 32'hBF800004);
    do_run(4);
    wait_done(100);
    check("special_err", err_count, 0);
    check("special_pass", pass, 1);
    check("special_vec", vec_count, 4);

    // Timeout on idx 0 with a late finish, idx 1 normal
    load(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    load(1, 2'd0, 32'h40000000, 32'h40000000, 32'h40800000);
    set_resp(0, 66, 32'h40400000);
    set_resp(1, 3, 32'h40800000);
    base = start_cnt;
    do_run(2);
    wait_done(300);
    check("tmo_gap", st_log[base + 1] - st_log[base], 67);
    check("tmo_seen", timeout_seen, 1);
    check("tmo_err", err_count, 1);
    check("tmo_first", first_fail, 0);
    check("tmo_vec", vec_count, 2);
    check("tmo_pass", pass, 0);

    // Zero vectors
    base = start_cnt;
    do_run(0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_pass", pass, 1);
    check("zero_busy", busy, 0);
    check("zero_starts", start_cnt - base, 0);

    // run and load_we while busy are ignored
    load(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    load(1, 2'd0, 32'h40000000, 32'h40000000, 32'h40800000);
    set_resp(0, 10, 32'h40400000);
    set_resp(1, 10, 32'h40800000);
    base = start_cnt;
    do_run(2);
    wait_start(base + 1, 20);
    load(1, 2'd0, 32'h12345678, 32'h0, 32'h0);
    do_run(1);
    wait_done(200);
    check("busy_vec", vec_count, 2);
    check("busy_load_a", a_log[base + 1], 32'h40000000);
    check("busy_starts", start_cnt - base, 2);
    check("busy_err", err_count, 0);

    // Reset mid-WAIT of the second of four vectors
    for (int i = 0; i < 4; i++) load(i, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_resp(0, 3, 32'h40400000);
    set_resp(1, 0, 32'h0);
    base = start_cnt;
    do_run(4);
    wait_start(base + 2, 50);
    repeat (5) @(negedge clk);
    check("pre_rst_vec", vec_count, 1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vec", vec_count, 0);
    check("mid_rst_a", fpu_a, 0);
    check("mid_rst_b", fpu_b, 0);
    check("mid_rst_start", fpu_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    for (int i = 0; i < 4; i++) set_resp(i, 2, 32'h40400000);
    do_run(4);
    wait_done(200);
    check("post_rst_vec", vec_count, 4);
    check("post_rst_err", err_count, 0);
    check("post_rst_pass", pass, 1);
    check("post_rst_tmo", timeout_seen, 0);

    check("start_one_cycle", wide_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fpu_selftest.md
# fpu_selftest

Synthesizable, parametrised self-test sequencer for the FPU. It holds a loadable vector memory of `{funct, a, b, expected}` entries and drives the FPU one operation at a time through a start/finish handshake. Each result is compared with the expected value within a programmable ULP tolerance, and the block reports error count, first failing index and timeouts. It sits beside the `fpu` instance and replaces simulation-only vector checking with on-chip checking usable in both simulation and silicon bring-up.

## Interface
Parameters:
- `EXP_W`, 8, exponent width; word width `W = 1+EXP_W+MAN_W`
- `MAN_W`, 23, mantissa width
- `DEPTH`, 1024, vector entries; `AW = $clog2(DEPTH)`
- `TOL_ULP`, 4, maximum accepted |ordered-key difference|
- `TIMEOUT`, 64, WAIT cycles without `fpu_finish` before the vector is failed

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `load_we`  in  1  write one vector entry
- `load_addr`  in  AW  entry index
- `load_data`  in  2+3W  `{funct, a, b, expected}`, funct in the MSBs
- `num_vectors`  in  AW+1  vectors to run; latched on `run`
- `run`  in  1  start pulse
- `fpu_start`  out  1  one-cycle operation request
- `fpu_funct`  out  2  operation code
- `fpu_a`, `fpu_b`  out  W  operands
- `fpu_o`  in  W  FPU result
- `fpu_finish`  in  1  result valid
- `busy`  out  1  sequence in progress
- `done`  out  1  sequence complete, held until next `run`
- `pass`  out  1  valid with `done`; 1 iff `err_count==0`
- `err_count`  out  AW+1  failing vectors, saturating
- `vec_count`  out  AW+1  vectors checked
- `first_fail`  out  AW  index of first failure; 0 if none
- `timeout_seen`  out  1  at least one vector timed out

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE + `run`: latch `num_vectors`, clear counters/flags, `done`=0, idx=0. Go to FETCH, or go directly to DONE with `pass`=1 if `num_vectors`==0.
- FETCH: synchronous memory read of entry idx (1-cycle latency).
- ISSUE: drive `fpu_funct/a/b`, pulse `fpu_start` for one cycle. Operands stay stable until the CHECK cycle ends.
- WAIT: sample `fpu_finish` from the cycle after `fpu_start`. On finish, capture `fpu_o` and go to CHECK. If TIMEOUT cycles pass without finish, mark the vector failed, set `timeout_seen`, and go to CHECK.
- CHECK: compare and update counters. If idx+1 == latched count go to DONE, else idx++ and go to FETCH.
- Compare rule:
  - Pass if bitwise equal.
  - Pass if both are NaN (exp all ones, mantissa ≠0), regardless of payload or sign.
  - Pass if both are zero, regardless of sign.
  - Otherwise form key(x) = x[W-1] ? ~x : x ^ (1<<(W-1)), as a W-bit unsigned value. Pass iff |key(o)−key(e)| ≤ TOL_ULP, computed in W+1 bits.
  - NaN vs non-NaN always fails.
- Failure updates: `err_count`++ (saturating at all-ones). On the first failure only, record `first_fail`=idx.
- `load_we` is ignored while `busy`. `run` is ignored while `busy`.

## Timing
- Reset values: state IDLE, all outputs 0 (`fpu_start`, `busy`, `done`, `pass`, counters, `first_fail`, `timeout_seen`, operands).
- `busy`=1 from the cycle after an accepted `run` until DONE is entered.
- `run` sampled in cycle 0 → FETCH in cycle 1 → `fpu_start` high in cycle 2.
- If finish arrives L cycles after start: CHECK at start+L+1, next `fpu_start` at start+L+3. Per-vector period is therefore L+3.
- Timeout: with no finish, CHECK occurs at start+TIMEOUT+1.
- `done`/`pass` are asserted the cycle after the final CHECK.
- `fpu_finish` seen outside WAIT is ignored. Finish during the `fpu_start` cycle is ignored.
- `rst_n` low mid-sequence: immediate return to the reset state, `fpu_start` deasserted asynchronously. Memory contents are not required to survive reset.
- `num_vectors` > DEPTH is clamped to DEPTH.

## Test plan
- Load entry 0 = {add, 0x3F800000, 0x40000000, 0x40400000}; model returns 0x40400000 at L=5 → `done` at start+6+1, `pass`=1, `vec_count`=1, `fpu_start` exactly one cycle.
- Expected 0x40400000, FPU returns 0x40400003 (TOL 4) → pass. Returns 0x40400005 → `err_count`=1, `first_fail`=0, `pass`=0.
- Three vectors, failures at idx 1 and 2 → `err_count`=2, `first_fail`=1. Also: expected 0x7FC00000 vs output 0xFFC00001 passes; expected 0x80000000 vs output 0x00000000 passes; 0x7F800000 vs NaN fails.
- FPU never finishes → CHECK at start+65, `timeout_seen`=1, sequence continues with the next vector; a finish arriving late is ignored.
- `num_vectors`=0 → `done`=1, `pass`=1 two cycles after `run`, no `fpu_start`. Re-`run` while busy and `load_we` while busy have no effect.
- Assert `rst_n` low mid-WAIT of vector 2 of 4 → all outputs 0 immediately. A new `run` after release restarts from idx 0 with cleared counters.
